hs_ram_arbiter: RTL and testbench

- Shares the game work-RAM port between the CPU and the hiscore save/restore engine.
- Sequences a CPU pause handshake before the hiscore engine is granted the port, muxes the RAM address, data and write lines, and returns the port after the engine releases it.
- Sits between the game core's RAM, its pause input and the hiscore module. Merges the user/OSD pause source into a single CPU pause output.

---
 rtl/hs_ram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_hs_ram_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter: shares the game work-RAM port between the CPU and the
// hiscore save/restore engine. The CPU is paused and allowed to settle before
// the engine is granted the port. When the engine releases the port, the pause
// stays up until in-flight acks drain.
// Optional build macro: HSARB_WATCHDOG_EN enables a HALT timeout that forces a
// grant and raises a sticky timeout_flag.
module hs_ram_arbiter #(
    parameter int AW      = 14,
    parameter int DW      = 8,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ce,
    input  logic          ext_pause,
    input  logic          cpu_halted,
    output logic          pause_cpu,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    input  logic          hs_req,
    output logic          hs_gnt,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_wdata,
    input  logic          hs_strobe,
    input  logic          hs_we,
    output logic [DW-1:0] hs_rdata,
    output logic          hs_ack,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata,
    output logic          timeout_flag
);

    typedef enum logic [1:0] {ST_IDLE, ST_HALT, ST_GRANT, ST_DRAIN} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_arb_pause;
    logic          w_gnt;
    logic [3:0]    r_settle;
    logic          w_settle_hit;
    logic          w_wd_hit;
    logic          w_acc;
    logic          w_pending;
    // r_vld_pipe[0]: access issued last cycle (RAM data now valid)
    // r_vld_pipe[1]: ack cycle
    logic [1:0]    r_vld_pipe;
    logic          r_rd_s1;
    logic [DW-1:0] r_rdata;

    // The settle target is reached on the ce that brings the count to SETTLE.
    assign w_settle_hit = cpu_halted && ce && (r_settle == 4'(SETTLE - 1));
    assign w_acc        = w_gnt && hs_strobe;
    assign w_pending    = |r_vld_pipe;

    assign pause_cpu = ext_pause || w_arb_pause;
    assign hs_gnt    = w_gnt;
    assign hs_ack    = r_vld_pipe[1];
    assign hs_rdata  = r_rdata;

    // State register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state and arbiter pause/grant decode
    always_comb begin
        w_next      = r_state;
        w_arb_pause = 1'b0;
        w_gnt       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (hs_req) w_next = ST_HALT;
            end
            ST_HALT: begin
                w_arb_pause = 1'b1;
                if (!hs_req)                       w_next = ST_IDLE;
                else if (w_settle_hit || w_wd_hit) w_next = ST_GRANT;
            end
            ST_GRANT: begin
                w_arb_pause = 1'b1;
                w_gnt       = 1'b1;
                if (!hs_req) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The ack must have issued before the ce counts, so the CPU
                // restarts at least one ce after the last completion.
                w_arb_pause = 1'b1;
                if (hs_req)                 w_next = ST_HALT;
                else if (!w_pending && ce)  w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Settle counter: counts ce while halted, cleared outside HALT or on halt loss
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)                                  r_settle <= '0;
        else if (r_state != ST_HALT || !cpu_halted) r_settle <= '0;
        else if (ce)                                r_settle <= r_settle + 4'd1;
    end

`ifdef HSARB_WATCHDOG_EN
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [WDW-1:0] r_wd;
    logic           r_timeout;

    assign w_wd_hit     = ce && (r_wd == WDW'(TIMEOUT - 1));
    assign timeout_flag = r_timeout;

    // Watchdog: ce pulses since HALT entry, regardless of cpu_halted
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)                   r_wd <= '0;
        else if (r_state != ST_HALT) r_wd <= '0;
        else if (ce)                 r_wd <= r_wd + WDW'(1);
    end

    // Sticky flag when the grant was forced rather than earned by settling
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            r_timeout <= 1'b0;
        else if (r_state == ST_HALT && hs_req && w_wd_hit && !w_settle_hit)
            r_timeout <= 1'b1;
    end
`else
    // No watchdog: HALT waits for the CPU indefinitely; flag folds to 0.
    assign w_wd_hit     = 1'b0;
    assign timeout_flag = (TIMEOUT < 0);
`endif

    // Fixed two-cycle access pipeline; read data captured as the RAM returns it
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_vld_pipe <= '0;
            r_rd_s1    <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], w_acc};
            r_rd_s1    <= w_acc && !hs_we;
            if (r_vld_pipe[0] && r_rd_s1) r_rdata <= ram_rdata;
        end
    end

    // RAM port mux: engine side only while granted, CPU side otherwise
    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = cpu_we;
        if (w_gnt) begin
            ram_addr  = hs_addr;
            ram_wdata = hs_wdata;
            ram_we    = hs_strobe && hs_we;
        end
    end

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Bench for hs_ram_arbiter: a RAM model with 1-clock read latency, plus a
// reference model of memory contents, settle/watchdog counts and ack timing.
module tb_hs_ram_arbiter;
    localparam int AW = 14, DW = 8, SETTLE = 2, TIMEOUT = 8;

    logic          clk_sys = 1'b0, reset = 1'b1, ce = 1'b0, ext_pause = 1'b0, cpu_halted = 1'b0;
    logic          pause_cpu, hs_gnt, hs_ack, ram_we, timeout_flag;
    logic [AW-1:0] cpu_addr = '0, hs_addr = '0, ram_addr;
    logic [DW-1:0] cpu_wdata = '0, hs_wdata = '0, hs_rdata, ram_wdata, ram_rdata;
    logic          cpu_we = 1'b0, hs_req = 1'b0, hs_strobe = 1'b0, hs_we = 1'b0;

    logic [DW-1:0] mem  [0:(1<<AW)-1];
    logic [DW-1:0] gold [0:(1<<AW)-1];
    logic [DW-1:0] exp_rd = '0;
    logic          exp_tflag = 1'b0;
    int            errors = 0, checks = 0;

    typedef struct { bit s; bit w; logic [AW-1:0] a; logic [DW-1:0] d; } acc_t;
    typedef struct { int due; bit rd; logic [DW-1:0] data; } pend_t;
    acc_t stim[$];

    hs_ram_arbiter #(.AW(AW), .DW(DW), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys(clk_sys), .reset(reset), .ce(ce), .ext_pause(ext_pause),
        .cpu_halted(cpu_halted), .pause_cpu(pause_cpu), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .hs_req(hs_req), .hs_gnt(hs_gnt),
        .hs_addr(hs_addr), .hs_wdata(hs_wdata), .hs_strobe(hs_strobe), .hs_we(hs_we),
        .hs_rdata(hs_rdata), .hs_ack(hs_ack), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_rdata(ram_rdata), .timeout_flag(timeout_flag)
    );

    always #5 clk_sys = ~clk_sys;

    // Synchronous RAM, one clock read latency
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk_sys); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        exp_rd = '0; exp_tflag = 1'b0;
    endtask

    task automatic acquire();
        bit ok = 0;
        hs_req = 1'b1; cpu_halted = 1'b1; ce = 1'b1; hs_strobe = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = hs_gnt; end
        checks++; if (!ok) begin errors++; $display("FAIL acquire_timeout: got gnt=%0b want 1", hs_gnt); end
        ce = 1'b0;
    endtask

    task automatic release_port();
        bit ok = 0;
        hs_req = 1'b0; ce = 1'b1; hs_strobe = 1'b0; cpu_we = 1'b0; ext_pause = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = !hs_gnt && !pause_cpu; end
        checks++; if (!ok) begin errors++; $display("FAIL release_timeout: got pause=%0b want 0", pause_cpu); end
        ce = 1'b0;
    endtask

    // Runs stim[] in GRANT, one entry per cycle, against the memory/ack model
    task automatic run_access();
        pend_t pend[$];
        pend_t p;
        bit    exp_a;
        int    n = stim.size();
        for (int i = 0; i < n + 3; i++) begin
            if (i < n) begin
                hs_strobe = stim[i].s; hs_we = stim[i].w; hs_addr = stim[i].a; hs_wdata = stim[i].d;
            end else begin
                hs_strobe = 1'b0; hs_we = 1'b0;
            end
            cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 14'($urandom_range(0, 16383));
            cpu_wdata = 8'($urandom_range(0, 255));
            #1;
            checks++; if (ram_we !== (hs_strobe && hs_we)) begin errors++; $display("FAIL acc_ram_we[%0d]: got %0b want %0b", i, ram_we, hs_strobe && hs_we); end
            checks++; if (ram_addr !== hs_addr) begin errors++; $display("FAIL acc_ram_addr[%0d]: got %h want %h", i, ram_addr, hs_addr); end
            if (hs_strobe) begin
                if (hs_we) begin
                    checks++; if (ram_wdata !== hs_wdata) begin errors++; $display("FAIL acc_ram_wdata[%0d]: got %h want %h", i, ram_wdata, hs_wdata); end
                    gold[hs_addr] = hs_wdata; p.rd = 1'b0; p.data = '0;
                end else begin
                    p.rd = 1'b1; p.data = gold[hs_addr];
                end
                p.due = i + 2; pend.push_back(p);
            end
            tick();
            exp_a = 1'b0;
            if (pend.size() > 0 && pend[0].due == i + 1) begin
                p = pend.pop_front(); exp_a = 1'b1;
                if (p.rd) exp_rd = p.data;
            end
            checks++; if (hs_ack !== exp_a) begin errors++; $display("FAIL acc_ack[%0d]: got %0b want %0b", i, hs_ack, exp_a); end
            checks++; if (hs_rdata !== exp_rd) begin errors++; $display("FAIL acc_rdata[%0d]: got %h want %h", i, hs_rdata, exp_rd); end
        end
        cpu_we = 1'b0;
        stim.delete();
    endtask

    // Model: settle count resets when not halted, grows per ce; watchdog counts every ce
    task automatic settle_run(input bit rnd);
        int n = 0, wd = 0;
        bit g = 0, ce_now, h_now;
        for (int c = 0; c < 60 && !g; c++) begin
            if (rnd && c < 40) begin
                ce = 1'($urandom_range(0, 1)); cpu_halted = ($urandom_range(0, 3) != 0);
            end else begin
                ce = rnd ? 1'b1 : ((c % 2) == 1); cpu_halted = 1'b1;
            end
            ce_now = ce; h_now = cpu_halted;
            tick();
            if (!h_now) n = 0; else if (ce_now) n++;
            if (ce_now) wd++;
            g = (n >= SETTLE);
`ifdef HSARB_WATCHDOG_EN
            if (!g && wd >= TIMEOUT) begin g = 1'b1; exp_tflag = 1'b1; end
`endif
            checks++; if (hs_gnt !== g) begin errors++; $display("FAIL settle_gnt[%0d]: got %0b want %0b", c, hs_gnt, g); end
            checks++; if (pause_cpu !== 1'b1) begin errors++; $display("FAIL settle_pause[%0d]: got %0b want 1", c, pause_cpu); end
            checks++; if (timeout_flag !== exp_tflag) begin errors++; $display("FAIL settle_tflag[%0d]: got %0b want %0b", c, timeout_flag, exp_tflag); end
        end
        checks++; if (!g) begin errors++; $display("FAIL settle_timeout: got gnt=%0b want 1", hs_gnt); end
        ce = 1'b0;
    endtask

    task automatic test_reset();
        cpu_addr = 14'h1234; hs_addr = 14'h0777; ext_pause = 1'b1;
        tick(); tick();
        checks++; if (pause_cpu !== 1'b1) begin errors++; $display("FAIL rst_pause_ext1: got %0b want 1", pause_cpu); end
        ext_pause = 1'b0; #1;
        checks++; if (pause_cpu !== 1'b0) begin errors++; $display("FAIL rst_pause_ext0: got %0b want 0", pause_cpu); end
        checks++; if (hs_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %0b want 0", hs_gnt); end
        checks++; if (ram_addr !== 14'h1234) begin errors++; $display("FAIL rst_ram_addr: got %h want 1234", ram_addr); end
        checks++; if (hs_ack !== 1'b0 || hs_rdata !== 8'h00) begin errors++; $display("FAIL rst_ack_rdata: got %0b/%h want 0/00", hs_ack, hs_rdata); end
        checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL rst_tflag: got %0b want 0", timeout_flag); end
        reset = 1'b0; tick();
        for (int i = 0; i < 4; i++) begin
            ext_pause = 1'($urandom_range(0, 1)); #1;
            checks++; if (pause_cpu !== ext_pause) begin errors++; $display("FAIL idle_pause[%0d]: got %0b want %0b", i, pause_cpu, ext_pause); end
            tick();
        end
        // reset mid-GRANT with a read in flight
        ext_pause = 1'b0;
        acquire();
        hs_addr = 14'h0010; hs_we = 1'b0; hs_strobe = 1'b1;
        tick();
        hs_strobe = 1'b0; cpu_addr = 14'h3ABC;
        #2 reset = 1'b1; #1;
        checks++; if (hs_gnt !== 1'b0) begin errors++; $display("FAIL midrst_gnt: got %0b want 0", hs_gnt); end
        checks++; if (ram_addr !== 14'h3ABC) begin errors++; $display("FAIL midrst_ram_addr: got %h want 3abc", ram_addr); end
        checks++; if (pause_cpu !== 1'b0) begin errors++; $display("FAIL midrst_pause: got %0b want 0", pause_cpu); end
        hs_req = 1'b0; cpu_halted = 1'b0;
        tick(); reset = 1'b0; exp_rd = '0; exp_tflag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (hs_ack !== 1'b0) begin errors++; $display("FAIL midrst_ack[%0d]: got %0b want 0", i, hs_ack); end
            tick();
        end
    endtask

    task automatic test_handshake();
        // hs_req rises together with a CPU write: the write still lands
        ext_pause = 1'b0; cpu_halted = 1'b1; ce = 1'b0;
        cpu_addr = 14'h0200; cpu_wdata = 8'hC3; cpu_we = 1'b1; hs_req = 1'b1; #1;
        checks++; if (ram_we !== 1'b1 || ram_addr !== 14'h0200) begin errors++; $display("FAIL hsk_cpu_write: got we=%0b addr=%h want 1/0200", ram_we, ram_addr); end
        checks++; if (pause_cpu !== 1'b0) begin errors++; $display("FAIL hsk_pause_idle: got %0b want 0", pause_cpu); end
        gold[14'h0200] = 8'hC3;
        tick(); cpu_we = 1'b0;
        checks++; if (pause_cpu !== 1'b1 || hs_gnt !== 1'b0) begin errors++; $display("FAIL hsk_halt_entry: got pause=%0b gnt=%0b want 1/0", pause_cpu, hs_gnt); end
        settle_run(1'b0);
    endtask

    task automatic test_access();
        stim.push_back('{1'b1, 1'b1, 14'h0123, 8'h5A});
        stim.push_back('{1'b1, 1'b0, 14'h0123, 8'h00});
        stim.push_back('{1'b0, 1'b0, 14'h0000, 8'h00});
        stim.push_back('{1'b1, 1'b0, 14'h0200, 8'h00});
        run_access();
        for (int i = 0; i < 30; i++)
            stim.push_back('{($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                             14'($urandom_range(0, 7) + 'h100), 8'($urandom_range(0, 255))});
        run_access();
    endtask

    task automatic test_cpu_blocked();
        cpu_addr = 14'h0123; cpu_wdata = 8'hFF; cpu_we = 1'b1; hs_strobe = 1'b0; hs_addr = 14'h0040; #1;
        checks++; if (ram_we !== 1'b0 || ram_addr !== 14'h0040) begin errors++; $display("FAIL blk_cpu_we: got we=%0b addr=%h want 0/0040", ram_we, ram_addr); end
        tick(); cpu_we = 1'b0;
        stim.push_back('{1'b1, 1'b0, 14'h0123, 8'h00});
        run_access();
        checks++; if (hs_rdata !== 8'h5A) begin errors++; $display("FAIL blk_readback: got %h want 5a", hs_rdata); end
    endtask

    task automatic test_drain();
        logic [DW-1:0] d;
        bit exp_p, exp_a, ce_now;
        cpu_addr = 14'h0055; cpu_we = 1'b0; ext_pause = 1'b0;
        hs_addr = 14'h0123; hs_we = 1'b0; hs_strobe = 1'b1; hs_req = 1'b0; ce = 1'b0;
        d = gold[14'h0123];
        tick(); hs_strobe = 1'b0;
        checks++; if (hs_gnt !== 1'b0 || ram_addr !== 14'h0055) begin errors++; $display("FAIL drn_release: got gnt=%0b addr=%h want 0/0055", hs_gnt, ram_addr); end
        checks++; if (pause_cpu !== 1'b1 || hs_ack !== 1'b0) begin errors++; $display("FAIL drn_first: got pause=%0b ack=%0b want 1/0", pause_cpu, hs_ack); end
        exp_p = 1'b1;
        for (int c = 1; c < 40 && exp_p; c++) begin
            ce = (c >= 12) ? 1'b1 : 1'($urandom_range(0, 1));
            ce_now = ce;
            tick();
            if (c >= 3 && ce_now) exp_p = 1'b0;
            exp_a = (c == 1);
            if (exp_a) exp_rd = d;
            checks++; if (pause_cpu !== exp_p) begin errors++; $display("FAIL drn_pause[%0d]: got %0b want %0b", c, pause_cpu, exp_p); end
            checks++; if (hs_ack !== exp_a) begin errors++; $display("FAIL drn_ack[%0d]: got %0b want %0b", c, hs_ack, exp_a); end
            checks++; if (hs_rdata !== exp_rd) begin errors++; $display("FAIL drn_rdata[%0d]: got %h want %h", c, hs_rdata, exp_rd); end
        end
        ce = 1'b0;
    endtask

    task automatic test_settle_random();
        for (int r = 0; r < 4; r++) begin
            ext_pause = 1'b1; hs_req = 1'b1; ce = 1'b0; cpu_halted = 1'b0;
            tick();
            settle_run(1'b1);
            release_port();
        end
    endtask

    task automatic test_halt_abort();
        hs_req = 1'b1; cpu_halted = 1'b1; ce = 1'b0; ext_pause = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (hs_gnt !== 1'b0 || pause_cpu !== 1'b1) begin errors++; $display("FAIL abort_wait[%0d]: got gnt=%0b pause=%0b want 0/1", i, hs_gnt, pause_cpu); end
        end
        hs_req = 1'b0; tick();
        checks++; if (pause_cpu !== 1'b0 || hs_gnt !== 1'b0) begin errors++; $display("FAIL abort_idle: got pause=%0b gnt=%0b want 0/0", pause_cpu, hs_gnt); end
    endtask

    task automatic test_watchdog();
`ifdef HSARB_WATCHDOG_EN
        int wd = 0;
        bit g = 0, ce_now;
        do_reset();
        hs_req = 1'b1; cpu_halted = 1'b0; ce = 1'b0;
        tick();
        for (int c = 0; c < 60 && !g; c++) begin
            ce = (c >= 30) ? 1'b1 : 1'($urandom_range(0, 1));
            ce_now = ce; tick();
            if (ce_now) wd++;
            g = (wd >= TIMEOUT);
            checks++; if (hs_gnt !== g) begin errors++; $display("FAIL wd_gnt[%0d]: got %0b want %0b", c, hs_gnt, g); end
            checks++; if (timeout_flag !== g) begin errors++; $display("FAIL wd_flag[%0d]: got %0b want %0b", c, timeout_flag, g); end
        end
        release_port();
        checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %0b want 1", timeout_flag); end
        do_reset();
        checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL wd_clear: got %0b want 0", timeout_flag); end
`else
        hs_req = 1'b1; cpu_halted = 1'b0; ce = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (hs_gnt !== 1'b0 || timeout_flag !== 1'b0) begin errors++; $display("FAIL nowd_wait[%0d]: got gnt=%0b flag=%0b want 0/0", i, hs_gnt, timeout_flag); end
        end
        hs_req = 1'b0; ce = 1'b0; tick();
        checks++; if (pause_cpu !== 1'b0) begin errors++; $display("FAIL nowd_idle: got %0b want 0", pause_cpu); end
`endif
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin mem[i] = '0; gold[i] = '0; end
        test_reset();
        test_handshake();
        test_access();
        test_cpu_blocked();
        test_drain();
        test_settle_random();
        test_halt_abort();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench timeout");
    end
endmodule
